// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the sequential restoring divider.
// The master side launches operands; the slave side (the divider) returns status and results.
interface seq_divider_if #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
);
    logic                  START;
    logic [DIVIDEND_W-1:0] INPUT_A;
    logic [DIVISOR_W-1:0]  INPUT_B;
    logic                  BUSY;
    logic                  DONE;
    logic [DIVIDEND_W-1:0] QUOT;
    logic [DIVISOR_W-1:0]  REM;
    logic                  DIV_ZERO;

    modport master (
        output START, INPUT_A, INPUT_B,
        input  BUSY, DONE, QUOT, REM, DIV_ZERO
    );

    modport slave (
        input  START, INPUT_A, INPUT_B,
        output BUSY, DONE, QUOT, REM, DIV_ZERO
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, DONE pulse in the
// cycle after the last iteration. Divide-by-zero short-circuits straight to FIN.
module seq_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_divider_if.slave bus
);
    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]            state_r,    state_nx;
    logic [DIVIDEND_W-1:0] dividend_r, dividend_nx;
    logic [DIVISOR_W-1:0]  divisor_r,  divisor_nx;
    logic [DIVISOR_W:0]    prem_r,     prem_nx;
    logic [CNT_W-1:0]      cnt_r,      cnt_nx;
    logic [DIVIDEND_W-1:0] quot_r,     quot_nx;
    logic [DIVISOR_W-1:0]  rem_r,      rem_nx;
    logic                  div_zero_r, div_zero_nx;
    logic                  busy_r;
    logic                  done_r;

    logic [DIVISOR_W+1:0]  shifted_s;
    logic [DIVISOR_W+1:0]  trial_s;
    logic                  qbit_s;
    logic [DIVISOR_W:0]    rem_step_s;
    logic [DIVIDEND_W-1:0] quot_step_s;

    // One restoring step: the dividend register doubles as the quotient shift register.
    always_comb begin
        shifted_s   = {prem_r, dividend_r[DIVIDEND_W-1]};
        trial_s     = shifted_s - {2'b00, divisor_r};
        qbit_s      = ~trial_s[DIVISOR_W+1];
        rem_step_s  = qbit_s ? trial_s[DIVISOR_W:0] : shifted_s[DIVISOR_W:0];
        quot_step_s = {dividend_r[DIVIDEND_W-2:0], qbit_s};
    end

    // Next-state and datapath update; results are only written on entry to FIN.
    always_comb begin
        state_nx    = state_r;
        dividend_nx = dividend_r;
        divisor_nx  = divisor_r;
        prem_nx     = prem_r;
        cnt_nx      = cnt_r;
        quot_nx     = quot_r;
        rem_nx      = rem_r;
        div_zero_nx = div_zero_r;
        case (state_r)
            IDLE: begin
                if (bus.START) begin
                    dividend_nx = bus.INPUT_A;
                    divisor_nx  = bus.INPUT_B;
                    prem_nx     = {(DIVISOR_W+1){1'b0}};
                    cnt_nx      = {CNT_W{1'b0}};
                    if (bus.INPUT_B != {DIVISOR_W{1'b0}}) begin
                        state_nx = RUN;
                    end else begin
                        state_nx    = FIN;
                        quot_nx     = {DIVIDEND_W{1'b1}};
                        rem_nx      = {DIVISOR_W{1'b0}};
                        div_zero_nx = 1'b1;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                prem_nx     = rem_step_s;
                dividend_nx = quot_step_s;
                cnt_nx      = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_ITER) begin
                    state_nx    = FIN;
                    quot_nx     = quot_step_s;
                    rem_nx      = rem_step_s[DIVISOR_W-1:0];
                    div_zero_nx = 1'b0;
                end else begin
                    state_nx = RUN;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            dividend_r <= {DIVIDEND_W{1'b0}};
            divisor_r  <= {DIVISOR_W{1'b0}};
            prem_r     <= {(DIVISOR_W+1){1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            quot_r     <= {DIVIDEND_W{1'b0}};
            rem_r      <= {DIVISOR_W{1'b0}};
            div_zero_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nx;
            dividend_r <= dividend_nx;
            divisor_r  <= divisor_nx;
            prem_r     <= prem_nx;
            cnt_r      <= cnt_nx;
            quot_r     <= quot_nx;
            rem_r      <= rem_nx;
            div_zero_r <= div_zero_nx;
            busy_r     <= (state_nx != IDLE);
            done_r     <= (state_nx == FIN);
        end
    end

    assign bus.BUSY     = busy_r;
    assign bus.DONE     = done_r;
    assign bus.QUOT     = quot_r;
    assign bus.REM      = rem_r;
    assign bus.DIV_ZERO = div_zero_r;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized
// operands compared against plain integer division.
module tb_seq_divider;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    seq_divider_if #(.DIVIDEND_W(16), .DIVISOR_W(8)) bus ();

    seq_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: quiet inputs, 1: random junk while busy, 2: one START pulse of 100/9 mid-run
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int mode);
        int lat;
        int busy_cycles;
        int exp_q;
        int exp_r;
        int exp_lat;
        exp_q   = (b == 8'd0) ? 65535 : int'(a) / int'(b);
        exp_r   = (b == 8'd0) ? 0 : int'(a) % int'(b);
        exp_lat = (b == 8'd0) ? 1 : 17;
        @(negedge clk);
        bus.START   = 1'b1;
        bus.INPUT_A = a;
        bus.INPUT_B = b;
        @(negedge clk);
        bus.START   = 1'b0;
        lat         = 1;
        busy_cycles = 0;
        while (!bus.DONE && lat < 40) begin
            if (bus.BUSY) busy_cycles++;
            if (mode == 1) begin
                bus.INPUT_A = 16'($urandom);
                bus.INPUT_B = 8'($urandom);
                bus.START   = 1'($urandom_range(0, 1));
            end else if (mode == 2 && lat == 5) begin
                bus.INPUT_A = 16'd100;
                bus.INPUT_B = 8'd9;
                bus.START   = 1'b1;
            end else begin
                bus.START = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.START = 1'b0;
        if (bus.BUSY) busy_cycles++;
        check_value("latency", lat, exp_lat);
        check_value("busy_cycles", busy_cycles, exp_lat);
        check_value("quot", bus.QUOT, exp_q);
        check_value("rem", bus.REM, exp_r);
        check_value("div_zero", bus.DIV_ZERO, (b == 8'd0) ? 1 : 0);
        @(negedge clk);
        check_value("done_one_cycle", bus.DONE, 0);
        check_value("busy_after", bus.BUSY, 0);
        check_value("quot_hold", bus.QUOT, exp_q);
    endtask

    initial begin
        logic [15:0] dir_a [9];
        logic [7:0]  dir_b [9];
        int          extra_done;
        int          t_first;
        int          t_second;
        int          cyc;

        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.START   = 1'b0;
        bus.INPUT_A = 16'd0;
        bus.INPUT_B = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("rst_busy", bus.BUSY, 0);
        check_value("rst_done", bus.DONE, 0);
        check_value("rst_quot", bus.QUOT, 0);
        check_value("rst_rem", bus.REM, 0);
        check_value("rst_div_zero", bus.DIV_ZERO, 0);

        dir_a = '{16'd40, 16'd1000, 16'd3, 16'd65535, 16'd65535, 16'd5, 16'd9, 16'd0, 16'd254};
        dir_b = '{8'd8, 8'd7, 8'd200, 8'd255, 8'd1, 8'd0, 8'd3, 8'd5, 8'd255};
        for (int i = 0; i < 9; i++) run_op(dir_a[i], dir_b[i], 0);

        // START while busy must be ignored, and only one DONE may appear
        run_op(16'd40, 8'd8, 2);
        extra_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.DONE) extra_done++;
        end
        check_value("no_second_done", extra_done, 0);

        // START held high: DONE-to-DONE spacing is DIVIDEND_W+2
        @(negedge clk);
        bus.START   = 1'b1;
        bus.INPUT_A = 16'd1000;
        bus.INPUT_B = 8'd7;
        t_first  = -1;
        t_second = -1;
        cyc      = 0;
        while (t_second < 0 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (bus.DONE) begin
                if (t_first < 0) t_first = cyc;
                else t_second = cyc;
                check_value("b2b_quot", bus.QUOT, 142);
            end
        end
        bus.START = 1'b0;
        check_value("b2b_period", t_second - t_first, 18);
        repeat (20) @(negedge clk);

        // async reset mid-operation
        @(negedge clk);
        bus.START   = 1'b1;
        bus.INPUT_A = 16'd1000;
        bus.INPUT_B = 8'd7;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_busy", bus.BUSY, 0);
        check_value("mid_rst_done", bus.DONE, 0);
        check_value("mid_rst_quot", bus.QUOT, 0);
        check_value("mid_rst_rem", bus.REM, 0);
        extra_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.DONE) extra_done++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.DONE) extra_done++;
        end
        check_value("mid_rst_no_done", extra_done, 0);
        run_op(16'd1000, 8'd7, 0);

        // randomized operands, with junk driven on the inputs while busy
        for (int i = 0; i < 30; i++) begin
            logic [15:0] ra;
            logic [7:0]  rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(ra, rb, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
